dfp_normalize96_seq: RTL

DFP_NORMALIZE96_SEQ -- requirements
Module: dfp_normalize96_seq

---
 rtl/dfp_normalize96_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dfp_normalize96_seq.sv
// DFP add/sub result normalizer: one digit of shift per enabled cycle.
// Params N (digits), INF_EXP; optional macro DFPNORM_FAST_SHIFT_EN.
// Ports: clk, rst_n (sync), ce, in_valid/in_ready, i_* unpacked input,
//        out_valid/out_ready, o_* normalized result (digits 2N..N).
module dfp_normalize96_seq #(
  parameter int          N       = 25,
  parameter logic [11:0] INF_EXP = 12'hBFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 i_sign,
  input  logic [11:0]          i_exp,
  input  logic [8*(N+1)-1:0]   i_sig,
  input  logic                 i_nan,
  input  logic                 i_qnan,
  input  logic                 i_snan,
  input  logic                 i_inf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 o_sign,
  output logic [11:0]          o_exp,
  output logic [4*(N+1)-1:0]   o_sig,
  output logic                 o_sticky,
  output logic                 o_under,
  output logic                 o_nan,
  output logic                 o_qnan,
  output logic                 o_snan,
  output logic                 o_inf
);

  localparam int W = 8*(N+1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t        state_q;
  logic [W-1:0]  sig_q, sig_d;
  logic [11:0]   exp_q, exp_d;
  logic          sign_q, nan_q, qnan_q, snan_q, inf_q;
  logic          stk_q, stk_d;
  logic          ostk_q, ound_q, oinf_q, ovalid_q;
  logic          fin, ovf, special, sig_zero, carry_nz, msd_z, und_d;

  assign special  = nan_q | inf_q | qnan_q | snan_q;
  assign sig_zero = (sig_q == '0);
  assign carry_nz = (sig_q[8*N+7:8*N+4] != 4'd0);
  assign msd_z    = (sig_q[8*N+3:8*N] == 4'd0);

  always_comb begin
    sig_d = sig_q;
    exp_d = exp_q;
    stk_d = stk_q;
    fin   = 1'b0;
    ovf   = 1'b0;
    if (special || sig_zero) begin
      fin = 1'b1;
    end else if (carry_nz) begin
      sig_d = sig_q >> 4;
      stk_d = stk_q | (|sig_q[3:0]);
      exp_d = exp_q + 12'd1;
      ovf   = (exp_d == INF_EXP);
      fin   = 1'b1;
    end else if (msd_z && exp_q != 12'd0) begin
`ifdef DFPNORM_FAST_SHIFT_EN
      // Top four digits clear and enough exponent: skip four at once.
      if (sig_q[8*N+3:8*N-12] == 16'd0 && exp_q >= 12'd4) begin
        sig_d = sig_q << 16;
        exp_d = exp_q - 12'd4;
      end else begin
        sig_d = sig_q << 4;
        exp_d = exp_q - 12'd1;
      end
`else
      sig_d = sig_q << 4;
      exp_d = exp_q - 12'd1;
`endif
    end else begin
      fin = 1'b1;
    end
    // Overflow to infinity drops the significand and sticky.
    if (ovf) begin
      sig_d = '0;
      stk_d = 1'b0;
    end
  end

  assign und_d = !special && !sig_zero && (exp_d == 12'd0) &&
                 (sig_d[8*N+3:8*N] == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sig_q    <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      nan_q    <= 1'b0;
      qnan_q   <= 1'b0;
      snan_q   <= 1'b0;
      inf_q    <= 1'b0;
      stk_q    <= 1'b0;
      ostk_q   <= 1'b0;
      ound_q   <= 1'b0;
      oinf_q   <= 1'b0;
      ovalid_q <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sig_q   <= i_sig;
            exp_q   <= i_exp;
            sign_q  <= i_sign;
            nan_q   <= i_nan;
            qnan_q  <= i_qnan;
            snan_q  <= i_snan;
            inf_q   <= i_inf;
            stk_q   <= 1'b0;
            state_q <= NORM;
          end
        end
        NORM: begin
          sig_q <= sig_d;
          exp_q <= exp_d;
          stk_q <= stk_d;
          if (fin) begin
            ostk_q   <= stk_d | (|sig_d[4*N-1:0]);
            ound_q   <= und_d;
            oinf_q   <= inf_q | ovf;
            ovalid_q <= 1'b1;
            state_q  <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            ovalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = ce & (state_q == IDLE);
  assign out_valid = ovalid_q;
  assign o_sign    = sign_q;
  assign o_exp     = exp_q;
  assign o_sig     = sig_q[8*N+3:4*N];
  assign o_sticky  = ostk_q;
  assign o_under   = ound_q;
  assign o_nan     = nan_q;
  assign o_qnan    = qnan_q;
  assign o_snan    = snan_q;
  assign o_inf     = oinf_q;

endmodule
